serial_digit_addsub: RTL and testbench
======================================

// Module: serial_digit_addsub
//
// PURPOSE
//   Serial adder/subtractor. Each valid beat carries one DIGIT_W-bit digit of
//   operands A and B, least-significant digit first; last marks the final digit.
//   Emits one registered result digit per beat, plus end-of-frame flags:
//   carry-out, signed overflow, zero and length error.
//   Used as the word-level arithmetic stage behind serialised operand streams.
//
// PARAMETERS
//   DIGIT_W    4  bits per beat (>=1)
//   MAX_BEATS  8  max digits per frame (>=2); a frame reaching it is force-terminated
//
// PORTS
//   clk        in   1        clock, all logic on rising edge
//   rst_n      in   1        synchronous reset, active low
//   vld        in   1        input beat valid
//   mode       in   1        0 = A+B, 1 = A-B; sampled only on first beat of a frame
//   a          in   DIGIT_W  operand A digit
//   b          in   DIGIT_W  operand B digit
//   last       in   1        final digit of frame; honoured only when vld=1
//   out_vld    out  1        result digit valid
//   sum        out  DIGIT_W  result digit
//   out_last   out  1        result digit is final digit of frame
//   carry_out  out  1        carry out of MSB (sub: 1 = no borrow); valid with out_last
//   ovf        out  1        two's-complement overflow of whole frame; valid with out_last
//   zero       out  1        every result digit of frame is 0; valid with out_last
//   len_err    out  1        frame force-terminated at MAX_BEATS; valid with out_last
//
// BEHAVIOUR
//   - States: IDLE (no frame open), BUSY (frame open).
//     IDLE + vld -> latch mode, beat 0; stay IDLE if last or MAX_BEATS==1, else BUSY.
//     BUSY + vld + (last | beat==MAX_BEATS-1) -> IDLE. vld=0 -> hold all state.
//   - Per beat: b_eff = mode_q ? ~b : b. cin = (first beat) ? mode : carry_q.
//     {c, s} = a + b_eff + cin, width DIGIT_W+1. carry_q <= c.
//     mode input is ignored on non-first beats; mode_q holds for the frame.
//   - Latency: exactly 1 cycle. Beat at edge N gives out_vld=1 and sum=s after edge N.
//     out_last is set on that output cycle if the beat closed the frame.
//     vld=0 at edge N gives out_vld=0 after edge N. No backpressure.
//   - Closing beat: carry_out=c; ovf = carry into MSB XOR c (MSB of last digit);
//     zero = (s==0) AND all earlier digits of frame were 0.
//     len_err=1 only when beat MAX_BEATS-1 arrives with last=0; it is treated as last.
//   - carry_out/ovf/zero/len_err are 0 whenever out_vld=0 or out_last=0.
//   - Back-to-back frames: beat after a closing beat is a new first beat
//     (mode re-sampled, cin=mode). No idle cycle is required.
//   - last with vld=0 is ignored and does not close the frame.
//   - rst_n=0 at an edge: state->IDLE; carry_q, beat count, zero accumulator = 0.
//     All outputs are 0 after that edge. An open frame is dropped, with no out_last.
//     A vld beat in the reset cycle is discarded.
//
// TESTING (DIGIT_W=4, MAX_BEATS=4)
//   1. add 0x35+0x4A: (a=5,b=A),(a=3,b=4,last)
//      -> sums F,7; out_last on 2nd; carry_out=0 ovf=0 zero=0 len_err=0
//   2. add 0x40+0x40: (0,0),(4,4,last)
//      -> sums 0,8; ovf=1 carry_out=0 zero=0
//   3. sub 0x12-0x12, mode=1 on beat0 and mode=0 on beat1: (2,2),(1,1,last)
//      -> sums 0,0; zero=1 carry_out=1 ovf=0 (beat1 mode ignored)
//   4. test 1 with vld=0 gaps, incl. last=1 while vld=0 mid-frame
//      -> identical sums/flags; out_vld=0 in each gap; frame not closed early
//   5. add, 4 beats (1,0)x4 with last=0
//      -> 4th output out_last=1 len_err=1; next (F,1,last) add gives sum 0, carry_out=1
//   6. add beat (F,1) then rst_n=0 one cycle, then add (0,0,last)
//      -> outputs 0 during reset; result sum=0 carry_out=0 (no stale carry)

Source files
------------

// File: rtl/serial_digit_addsub.sv
// Serial digit-wise adder/subtractor, LSD first, one registered result digit per beat.
// End-of-frame flags (carry, signed overflow, zero, length error) accompany out_last.
module serial_digit_addsub #(
    parameter int unsigned DIGIT_W   = 4,
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic               mode,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               last,
    output logic               out_vld,
    output logic [DIGIT_W-1:0] sum,
    output logic               out_last,
    output logic               carry_out,
    output logic               ovf,
    output logic               zero,
    output logic               len_err
);

    localparam int unsigned CntW = $clog2(MAX_BEATS);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     beat_q, beat_d, cur_beat;
    logic                carry_q, carry_d;
    logic                mode_q, mode_d;
    logic                zero_q, zero_d;

    logic                first, mode_eff, cin, at_max, close_beat;
    logic [DIGIT_W-1:0]  b_eff, s;
    logic                c, msb_cin;

    logic                out_vld_d, out_last_d, carry_out_d, ovf_d, zero_out_d, len_err_d;
    logic [DIGIT_W-1:0]  sum_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            carry_q   <= 1'b0;
            mode_q    <= 1'b0;
            zero_q    <= 1'b0;
            out_vld   <= 1'b0;
            sum       <= '0;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            carry_q   <= carry_d;
            mode_q    <= mode_d;
            zero_q    <= zero_d;
            out_vld   <= out_vld_d;
            sum       <= sum_d;
            out_last  <= out_last_d;
            carry_out <= carry_out_d;
            ovf       <= ovf_d;
            zero      <= zero_out_d;
            len_err   <= len_err_d;
        end
    end

    // First beat of a frame takes mode straight from the port; later beats use mode_q.
    always_comb begin
        first      = (state_q == StIdle);
        mode_eff   = first ? mode : mode_q;
        cin        = first ? mode : carry_q;
        b_eff      = mode_eff ? ~b : b;
        {c, s}     = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
        msb_cin    = a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ s[DIGIT_W-1];
        cur_beat   = first ? '0 : beat_q;
        at_max     = (cur_beat == CntW'(MAX_BEATS - 1));
        close_beat = last | at_max;

        state_d = state_q;
        beat_d  = beat_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        zero_d  = zero_q;
        if (vld) begin
            state_d = close_beat ? StIdle : StBusy;
            beat_d  = close_beat ? '0 : cur_beat + 1'b1;
            carry_d = c;
            mode_d  = mode_eff;
            zero_d  = (s == '0) & (first | zero_q);
        end
    end

    always_comb begin
        out_vld_d   = vld;
        sum_d       = vld ? s : '0;
        out_last_d  = vld & close_beat;
        carry_out_d = vld & close_beat & c;
        ovf_d       = vld & close_beat & (msb_cin ^ c);
        zero_out_d  = vld & close_beat & zero_d;
        len_err_d   = vld & at_max & ~last;
    end

endmodule

// File: tb/tb_serial_digit_addsub.sv
// Randomised and directed bench for serial_digit_addsub; expected results come from
// whole-word arithmetic on the digits collected so far in the open frame.
module tb_serial_digit_addsub;

    localparam int unsigned DW = 4;
    localparam int unsigned MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vld, mode, last;
    logic [DW-1:0] a, b;
    logic          out_vld, out_last, carry_out, ovf, zero, len_err;
    logic [DW-1:0] sum;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit     m_open = 0;
    bit     m_mode = 0;
    int     m_n    = 0;
    longint m_a    = 0;
    longint m_b    = 0;

    serial_digit_addsub #(
        .DIGIT_W  (DW),
        .MAX_BEATS(MB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .last     (last),
        .out_vld  (out_vld),
        .sum      (sum),
        .out_last (out_last),
        .carry_out(carry_out),
        .ovf      (ovf),
        .zero     (zero),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs (rst=1 asserts reset), then check outputs after the edge.
    task automatic step(input bit v, input bit m, input int aa, input int bb, input bit l,
                        input bit rst = 0);
        bit     e_vld = 0, e_last = 0, e_c = 0, e_ovf = 0, e_zero = 0, e_len = 0;
        longint e_sum = 0;
        longint w, modv, res, sa, sb, sr;
        rst_n = !rst;
        vld   = v;
        mode  = m;
        a     = DW'(aa);
        b     = DW'(bb);
        last  = l;
        if (rst) begin
            m_open = 0;
        end else if (v) begin
            if (!m_open) begin
                m_open = 1;
                m_mode = m;
                m_n    = 0;
                m_a    = 0;
                m_b    = 0;
            end
            m_a  |= longint'(aa & 'hF) << (DW * m_n);
            m_b  |= longint'(bb & 'hF) << (DW * m_n);
            m_n++;
            w     = DW * m_n;
            modv  = longint'(1) << w;
            res   = m_mode ? (m_a - m_b) : (m_a + m_b);
            res   = ((res % modv) + modv) % modv;
            e_vld = 1;
            e_sum = (res >> (DW * (m_n - 1))) & ((1 << DW) - 1);
            if (l || m_n == MB) begin
                e_last = 1;
                e_c    = m_mode ? (m_a >= m_b) : ((m_a + m_b) >= modv);
                sa     = (m_a >= modv / 2) ? m_a - modv : m_a;
                sb     = (m_b >= modv / 2) ? m_b - modv : m_b;
                sr     = m_mode ? sa - sb : sa + sb;
                e_ovf  = (sr >= modv / 2) || (sr < -(modv / 2));
                e_zero = (res == 0);
                e_len  = !l;
                m_open = 0;
            end
        end
        @(posedge clk);
        #1;
        check_eq("out_vld", out_vld, e_vld);
        if (e_vld || rst) check_eq("sum", sum, e_sum);
        check_eq("out_last", out_last, e_last);
        check_eq("carry_out", carry_out, e_c);
        check_eq("ovf", ovf, e_ovf);
        check_eq("zero", zero, e_zero);
        check_eq("len_err", len_err, e_len);
    endtask

    initial begin
        rst_n = 0; vld = 0; mode = 0; last = 0; a = '0; b = '0;
        step(1, 0, 3, 4, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // 0x35 + 0x4A
        step(1, 0, 5, 'hA, 0);
        step(1, 0, 3, 4, 1);
        // 0x40 + 0x40 overflows
        step(1, 0, 0, 0, 0);
        step(1, 0, 4, 4, 1);
        // 0x12 - 0x12, mode ignored on beat 1
        step(1, 1, 2, 2, 0);
        step(1, 0, 1, 1, 1);
        // test 1 with gaps, including last while vld=0
        step(1, 0, 5, 'hA, 0);
        step(0, 0, 9, 9, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 3, 4, 1);
        step(0, 0, 0, 0, 0);
        // forced termination at MAX_BEATS, then back-to-back frame
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 'hF, 1, 1);
        // reset drops open frame and carry
        step(1, 0, 'hF, 1, 0);
        step(1, 0, 'hF, 1, 0, 1);
        step(1, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
        end
        // occasional all-zero / equal-operand frames to hit the zero flag
        for (int i = 0; i < 200; i++) begin
            int d = $urandom_range(0, 15);
            step(1, $urandom_range(0, 1), d, ($urandom_range(0, 1) != 0) ? d : 0,
                 $urandom_range(0, 1) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
